// File: rtl/text_display_sequencer_pkg.sv
// Shared display definitions: sequencer state encoding and default message-ROM geometry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package text_display_sequencer_pkg;

  // Sequencer states; GAP and DONE each last exactly one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Default message count and index width, shared with the renderer's message ROM.
  localparam int DEF_MSG_COUNT = 8;
  localparam int DEF_IDX_W     = 3;

endpackage

// File: rtl/text_display_sequencer.sv
// Steps a text display through MSG_COUNT messages, one dwell-timer period per message.
// Latency: all outputs registered; start -> SHOW next cycle, timer_end -> GAP/DONE next cycle.
// Backpressure: hold freezes the current message and drops timer_en so the dwell restarts on release.
module text_display_sequencer
  import text_display_sequencer_pkg::*;
#(
  parameter int MSG_COUNT = DEF_MSG_COUNT,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int LOOP      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic             timer_end,
  output logic             timer_en,
  output logic [IDX_W-1:0] msg_idx,
  output logic             msg_valid,
  output logic             busy,
  output logic             done
);

  // Explicit last-index compare so non-power-of-two counts wrap correctly.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_COUNT - 1);

  seq_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             timer_en_nxt, msg_valid_nxt, busy_nxt, done_nxt;

  // Next-state, next-index and next-output decode; abort overrides everything.
  always_comb begin
    state_nxt = state;
    idx_nxt   = msg_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHOW;
          idx_nxt   = '0;
        end
      end
      SHOW: begin
        // An expiry that lands while frozen is dropped; the timer is being cleared anyway.
        if (timer_end && !hold) begin
          if (msg_idx == LAST_IDX) begin
            if (LOOP != 0) begin
              state_nxt = GAP;
              idx_nxt   = '0;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            state_nxt = GAP;
            idx_nxt   = msg_idx + 1'b1;
          end
        end
      end
      GAP: begin
        state_nxt = SHOW;
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase

    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end

    // Outputs are decoded from the state being entered so they can be registered.
    timer_en_nxt  = (state_nxt == SHOW) && !hold;
    msg_valid_nxt = (state_nxt == SHOW) || (state_nxt == GAP);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
  end

  // State and registered outputs, with synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      msg_idx   <= '0;
      timer_en  <= 1'b0;
      msg_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      msg_idx   <= idx_nxt;
      timer_en  <= timer_en_nxt;
      msg_valid <= msg_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule
